// File: rtl/pipeline_pkg.sv
// Shared definitions for the 5-stage pipeline control logic: hazard FSM
// state encoding, EX-stage forward-select codes and the register specifier width.
package pipeline_pkg;

  localparam int REG_ADDR_WIDTH = 2;

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    MEM_WAIT = 2'd1,
    HALT     = 2'd2
  } hz_state_e;

  localparam logic [1:0] FWD_RF  = 2'b00;
  localparam logic [1:0] FWD_MEM = 2'b10;
  localparam logic [1:0] FWD_WB  = 2'b01;

endpackage

// File: rtl/sat_counter.sv
// Up-counter that sticks at all-ones; used for the pipeline stall/flush
// performance counters.
module sat_counter #(
  parameter int WIDTH = 16
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_inc,
  output logic [WIDTH-1:0] o_cnt
);

  logic [WIDTH-1:0] cnt_q;
  logic [WIDTH-1:0] cnt_d;

  // NOTE: next-state defaults to the current value first, so no path leaves cnt_d unassigned (no latch).
  always_comb begin
    cnt_d = cnt_q;
    if (i_inc && (cnt_q != '1)) begin
      cnt_d = cnt_q + WIDTH'(1);
    end
  end

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign o_cnt = cnt_q;

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// Hazard/sequencing controller: EX forwarding, load-use stall, branch flush,
// and a global freeze with a memory-wait FSM that halts on a stuck access.
module pipeline_hazard_ctrl #(
  parameter int REG_ADDR_WIDTH = pipeline_pkg::REG_ADDR_WIDTH,
  parameter int MEM_TIMEOUT    = 15,
  parameter int CNT_WIDTH      = 16
) (
  input  logic                      i_clk,
  input  logic                      i_rst,
  input  logic [REG_ADDR_WIDTH-1:0] i_rs1_D,
  input  logic [REG_ADDR_WIDTH-1:0] i_rs2_D,
  input  logic [REG_ADDR_WIDTH-1:0] i_rs1_E,
  input  logic [REG_ADDR_WIDTH-1:0] i_rs2_E,
  input  logic [REG_ADDR_WIDTH-1:0] i_rd_E,
  input  logic                      i_regWrite_E,
  input  logic                      i_memRead_E,
  input  logic                      i_branch_taken_E,
  input  logic [REG_ADDR_WIDTH-1:0] i_rd_M,
  input  logic [REG_ADDR_WIDTH-1:0] i_rd_W,
  input  logic                      i_regWrite_M,
  input  logic                      i_regWrite_W,
  input  logic                      i_mem_req_M,
  input  logic                      i_mem_ack,
  output logic                      o_stallF,
  output logic                      o_stallD,
  output logic                      o_flushD,
  output logic                      o_flushE,
  output logic                      o_freeze,
  output logic [1:0]                o_fwdA_E,
  output logic [1:0]                o_fwdB_E,
  output logic                      o_mem_timeout,
  output logic                      o_halted,
  output logic [CNT_WIDTH-1:0]      o_stall_cnt,
  output logic [CNT_WIDTH-1:0]      o_flush_cnt
);

  import pipeline_pkg::*;

  localparam int                WAIT_W    = (MEM_TIMEOUT > 2) ? $clog2(MEM_TIMEOUT) : 1;
  localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(MEM_TIMEOUT - 1);

  hz_state_e         state_q, state_d;
  logic [WAIT_W-1:0] wait_cnt_q, wait_cnt_d;
  logic              mem_timeout_q, mem_timeout_d;

  logic mem_stuck;
  logic load_use;
  logic stall_inc;
  logic flush_inc;

  assign mem_stuck = i_mem_req_M & ~i_mem_ack;
  assign load_use  = i_memRead_E & i_regWrite_E &
                     ((i_rd_E == i_rs1_D) | (i_rd_E == i_rs2_D));

  // Memory-wait FSM; wait_cnt counts consecutive un-acked cycles.
  always_comb begin
    state_d       = state_q;
    wait_cnt_d    = wait_cnt_q;
    case (state_q)
      RUN: begin
        if (mem_stuck) begin
          state_d    = MEM_WAIT;
          wait_cnt_d = wait_cnt_q + WAIT_W'(1);
        end else begin
          wait_cnt_d = '0;
        end
      end
      MEM_WAIT: begin
        if (!mem_stuck) begin
          state_d    = RUN;
          wait_cnt_d = '0;
        end else if (wait_cnt_q == WAIT_LAST) begin
          state_d    = HALT;
        end else begin
          wait_cnt_d = wait_cnt_q + WAIT_W'(1);
        end
      end
      default: state_d = HALT;
    endcase
    mem_timeout_d = (state_d == HALT) && (state_q != HALT);
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q       <= RUN;
      wait_cnt_q    <= '0;
      mem_timeout_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      wait_cnt_q    <= wait_cnt_d;
      mem_timeout_q <= mem_timeout_d;
    end
  end

  // Combinational hazard outputs; priority is halt > freeze > branch > load-use.
  always_comb begin
    o_stallF  = 1'b0;
    o_stallD  = 1'b0;
    o_flushD  = 1'b0;
    o_flushE  = 1'b0;
    o_freeze  = 1'b0;
    o_fwdA_E  = FWD_RF;
    o_fwdB_E  = FWD_RF;
    stall_inc = 1'b0;
    flush_inc = 1'b0;
    if (!i_rst) begin
      if (state_q == HALT) begin
        o_freeze = 1'b1;
      end else begin
        if (i_regWrite_M && (i_rd_M == i_rs1_E))      o_fwdA_E = FWD_MEM;
        else if (i_regWrite_W && (i_rd_W == i_rs1_E)) o_fwdA_E = FWD_WB;
        if (i_regWrite_M && (i_rd_M == i_rs2_E))      o_fwdB_E = FWD_MEM;
        else if (i_regWrite_W && (i_rd_W == i_rs2_E)) o_fwdB_E = FWD_WB;

        if (mem_stuck) begin
          o_freeze  = 1'b1;
          stall_inc = 1'b1;
        end else if (i_branch_taken_E) begin
          o_flushD  = 1'b1;
          o_flushE  = 1'b1;
          flush_inc = 1'b1;
        end else if (load_use) begin
          o_stallF  = 1'b1;
          o_stallD  = 1'b1;
          o_flushE  = 1'b1;
          stall_inc = 1'b1;
        end
      end
    end
  end

  assign o_mem_timeout = mem_timeout_q;
  assign o_halted      = (state_q == HALT);

  sat_counter #(.WIDTH(CNT_WIDTH)) u_stall_cnt (
    .i_clk (i_clk),
    .i_rst (i_rst),
    .i_inc (stall_inc),
    .o_cnt (o_stall_cnt)
  );

  sat_counter #(.WIDTH(CNT_WIDTH)) u_flush_cnt (
    .i_clk (i_clk),
    .i_rst (i_rst),
    .i_inc (flush_inc),
    .o_cnt (o_flush_cnt)
  );

endmodule
